// File: rtl/dff_pkg.sv
// Shared constants for the dff storage cell.
package dff_pkg;

    // One bit unless the instantiating register, counter or shift chain asks for more.
    localparam int unsigned DFF_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/dff_if.sv
// Data-side bundle of a dff: d toward the cell, q/qbar back from it.
interface dff_if
    import dff_pkg::*;
#(
    parameter int unsigned WIDTH = DFF_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;

    modport master (output d, input q, input qbar);
    modport slave  (input d, output q, output qbar);
endinterface

// File: rtl/dff_d_latch.sv
// Level-sensitive gated D latch with complementary outputs.
module dff_d_latch (
    output logic q,
    output logic qbar,
    input  logic d,
    input  logic en
);

    // Transparent while en is high. Both rails are updated in the same
    // place, so qbar can never equal q.
    always_latch begin
        if (en) begin
            q    <= d;
            qbar <= ~d;
        end
    end

endmodule

// File: rtl/dff.sv
// Positive-edge D flip-flop with complementary outputs and synchronous clear.
// Built as a master-slave pair of latches per bit; clear gates the master's
// data input, so it only takes effect through the normal capture at the
// rising edge and there is no path from d or clr straight to q/qbar.
// Port order q, qbar, d, clk, clr is relied on by positional instantiations.
module dff
    import dff_pkg::*;
#(
    parameter int unsigned WIDTH = DFF_DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             clr
);

    logic             clk_n;
    logic [WIDTH-1:0] data_gated;

    assign clk_n      = ~clk;
    // Clear wins over data: the master only ever sees zero while clr is high.
    assign data_gated = clr ? '0 : d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic master_q;
        logic master_qbar_unused;

        // Master follows the gated data while clk is low and freezes at the rising edge.
        dff_d_latch u_master (
            .q    (master_q),
            .qbar (master_qbar_unused),
            .d    (data_gated[i]),
            .en   (clk_n)
        );

        // Slave passes the frozen master value while clk is high and holds it while clk is low.
        dff_d_latch u_slave (
            .q    (q[i]),
            .qbar (qbar[i]),
            .d    (master_q),
            .en   (clk)
        );
    end

endmodule

// File: tb/tb_dff.sv
// Directed bench for dff: timed sequences on a 1-bit cell, then a vector
// table on a 4-bit cell.
module tb_dff;

    logic clk = 1'b0;
    logic clr1;
    logic clr4;

    int nvec = 0;
    int nmis = 0;

    dff_if #(.WIDTH(1)) bus1 ();
    dff_if #(.WIDTH(4)) bus4 ();

    dff #(.WIDTH(1)) u_dff1 (
        .q    (bus1.q),
        .qbar (bus1.qbar),
        .d    (bus1.d),
        .clk  (clk),
        .clr  (clr1)
    );

    dff #(.WIDTH(4)) u_dff4 (
        .q    (bus4.q),
        .qbar (bus4.qbar),
        .d    (bus4.d),
        .clk  (clk),
        .clr  (clr4)
    );

    // Period 10 ns, first rising edge at 5 ns.
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic [3:0] d;
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic exp_q);
        chk({name, ".q"},    {3'b000, bus1.q},    {3'b000, exp_q});
        chk({name, ".qbar"}, {3'b000, bus1.qbar}, {3'b000, ~exp_q});
    endtask

    task automatic at(input longint t);
        #(t - longint'($time));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_q;

        vecs[0] = '{clr: 1'b0, d: 4'b1010, exp_q: 4'b1010};
        vecs[1] = '{clr: 1'b1, d: 4'b0101, exp_q: 4'b0000};
        vecs[2] = '{clr: 1'b0, d: 4'b1111, exp_q: 4'b1111};
        vecs[3] = '{clr: 1'b0, d: 4'b0000, exp_q: 4'b0000};
        vecs[4] = '{clr: 1'b1, d: 4'b1111, exp_q: 4'b0000};
        vecs[5] = '{clr: 1'b0, d: 4'b0110, exp_q: 4'b0110};
        vecs[6] = '{clr: 1'b0, d: 4'b1001, exp_q: 4'b1001};
        vecs[7] = '{clr: 1'b1, d: 4'b0000, exp_q: 4'b0000};

        clr1   = 1'b1;
        bus1.d = 'x;
        clr4   = 1'b1;
        bus4.d = 4'b0000;

        // Clear at start
        at(6);   chk1("clear_after_5ns", 1'b0);
        at(26);  chk1("clear_held_25ns", 1'b0);

        // Set
        at(29);  clr1 = 1'b0; bus1.d = 1'b1;
        at(33);  chk1("set_before_edge", 1'b0);
        at(36);  chk1("set_after_35ns", 1'b1);

        // Reset via data
        at(59);  bus1.d = 1'b0;
        at(63);  chk1("d0_before_edge", 1'b1);
        at(66);  chk1("d0_after_65ns", 1'b0);

        // Synchronous clear, d held high
        at(89);  bus1.d = 1'b1;
        at(96);  chk1("reload_95ns", 1'b1);
        at(117); clr1 = 1'b1;
        at(118); chk1("clr_no_async_118", 1'b1);
        at(124); chk1("clr_no_async_124", 1'b1);
        at(126); chk1("clr_edge_125ns", 1'b0);
        at(147); chk1("clr_held_147ns", 1'b0);

        // Glitch immunity
        at(149); clr1 = 1'b0; bus1.d = 1'b0;
        at(156); chk1("glitch_base", 1'b0);
                 bus1.d = 1'b1;
        at(158); bus1.d = 1'b0;
        at(159); chk1("glitch_high_phase", 1'b0);
        at(161); bus1.d = 1'b1;
        at(162); bus1.d = 1'b0;
        at(164); chk1("glitch_low_phase", 1'b0);
        at(166); chk1("glitch_low_settled0", 1'b0);
        at(171); bus1.d = 1'b1;
        at(172); bus1.d = 1'b0;
        at(173); bus1.d = 1'b1;
        at(174); chk1("glitch_low_hold", 1'b0);
        at(176); chk1("glitch_low_settled1", 1'b1);
        at(177); bus1.d = 1'b0;
        at(178); bus1.d = 1'b1;
        at(179); chk1("glitch_high_q1", 1'b1);

        // Clear pulse that drops before the edge lets d load
        at(181); clr1 = 1'b1;
        at(183); clr1 = 1'b0;
        at(184); chk1("clr_pulse_hold", 1'b1);
        at(186); chk1("clr_pulse_released", 1'b1);

        // 4-bit vector table
        at(187);
        chk("w4_reset.q",    bus4.q,    4'b0000);
        chk("w4_reset.qbar", bus4.qbar, 4'b1111);
        prev_q = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            clr4   = vecs[i].clr;
            bus4.d = vecs[i].d;
            #1;
            chk($sformatf("w4_hold[%0d].q", i), bus4.q, prev_q);
            @(posedge clk);
            #1;
            chk($sformatf("w4_vec[%0d].q", i),    bus4.q,    vecs[i].exp_q);
            chk($sformatf("w4_vec[%0d].qbar", i), bus4.qbar, ~vecs[i].exp_q);
            prev_q = vecs[i].exp_q;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
